// File: rtl/cpu_types_pkg.sv
// Shared cache types: address-split widths, frame metadata and the data cache
// controller states.
package cpu_types_pkg;
    localparam int WORD_W = 32;

    function automatic int boff_w(input int words);
        return $clog2(words);
    endfunction

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int sets, input int words);
        return WORD_W - 2 - boff_w(words) - idx_w(sets);
    endfunction

    // Counter width; a single-entry range still needs one bit of storage.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Tags are held zero-extended to a full word so one frame type fits every geometry.
    typedef struct packed {
        logic              valid;
        logic              dirty;
        logic [WORD_W-1:0] tag;
    } frame_t;

    typedef enum logic [2:0] {IDLE, WB, ALLOC, FLUSH, DONE} dstate_t;
endpackage

// File: rtl/dcache_set_array.sv
// Tag/data store: combinational read of every way of one set, one word write
// port plus an independent frame metadata write.
module dcache_set_array import cpu_types_pkg::*; #(
    parameter int SETS  = 8,
    parameter int WAYS  = 2,
    parameter int WORDS = 2,
    localparam int IW  = idx_w(SETS),
    localparam int WYW = cnt_w(WAYS),
    localparam int WCW = cnt_w(WORDS)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [IW-1:0]                          rd_idx,
    output frame_t [WAYS-1:0]                      rd_meta,
    output logic [WAYS-1:0][WORDS-1:0][WORD_W-1:0] rd_data,
    input  logic                                   data_we,
    input  logic                                   meta_we,
    input  logic [IW-1:0]                          wr_idx,
    input  logic [WYW-1:0]                         wr_way,
    input  logic [WCW-1:0]                         wr_word,
    input  logic [WORD_W-1:0]                      wr_data,
    input  frame_t                                 wr_meta
);
    frame_t [WAYS-1:0]                      meta [SETS];
    logic [WAYS-1:0][WORDS-1:0][WORD_W-1:0] data [SETS];

    assign rd_meta = meta[rd_idx];
    assign rd_data = data[rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) meta[s] <= '0;
        end else if (meta_we) begin
            meta[wr_idx][wr_way] <= wr_meta;
        end
    end

    // Data words need no reset: nothing is readable until its frame is valid.
    always_ff @(posedge clk) begin
        if (data_we) data[wr_idx][wr_way][wr_word] <= wr_data;
    end
endmodule

// File: rtl/dcache_assoc.sv
// Write-back, write-allocate N-way data cache with round-robin victims and a
// halt-triggered flush of every dirty frame.
module dcache_assoc import cpu_types_pkg::*; #(
    parameter int SETS  = 8,
    parameter int WAYS  = 2,
    parameter int WORDS = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    input  logic        halt,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic        dwait,
    input  logic [31:0] dload
);
    localparam int IW      = idx_w(SETS);
    localparam int WYW     = cnt_w(WAYS);
    localparam int WCW     = cnt_w(WORDS);
    localparam int IDX_LSB = 2 + boff_w(WORDS);
    localparam int TAG_LSB = IDX_LSB + IW;

    dstate_t state, nstate;
    logic [IW-1:0]     req_idx, miss_idx, fset, rd_idx, wr_idx;
    logic [WCW-1:0]    req_word, wcnt, wr_word;
    logic [WORD_W-1:0] req_tag, miss_tag, wr_data;
    logic [WYW-1:0]    hit_way, vsel, vway, fway, wr_way;
    logic [WYW-1:0]    rr [SETS];
    frame_t [WAYS-1:0] rd_meta;
    frame_t            wr_meta, fframe;
    logic [WAYS-1:0][WORDS-1:0][WORD_W-1:0] rd_data;
    logic hit, vfound, req, xfer, wlast, flast, fdirty, fstep, data_we, meta_we, unused_bits;

    function automatic logic [31:0] blk_addr(input logic [WORD_W-1:0] t, input logic [IW-1:0] i,
                                             input logic [WCW-1:0] w);
        return (t << TAG_LSB) | (32'(i) << IDX_LSB) | (32'(w) << 2);
    endfunction

    assign req_idx     = dmemaddr[IDX_LSB +: IW];
    assign req_word    = WCW'(dmemaddr >> 2) & WCW'(WORDS - 1);
    assign req_tag     = dmemaddr >> TAG_LSB;
    assign unused_bits = ^dmemaddr[1:0];
    assign req         = dmemREN | dmemWEN;
    assign wlast       = (wcnt == WCW'(WORDS - 1));
    assign flast       = (fway == WYW'(WAYS - 1)) && (fset == IW'(SETS - 1));
    assign fframe      = rd_meta[fway];
    assign fdirty      = fframe.valid & fframe.dirty;
    assign xfer        = (dREN | dWEN) & ~dwait;
    assign fstep       = (state == FLUSH) && (!fdirty || (xfer && wlast));

    // The miss set stays addressed through WB/ALLOC so the victim's tag and data remain visible.
    assign rd_idx = (state == IDLE) ? req_idx : (state == FLUSH) ? fset : miss_idx;

    dcache_set_array #(.SETS(SETS), .WAYS(WAYS), .WORDS(WORDS)) u_array (
        .clk(CLK), .rst(RST), .rd_idx(rd_idx), .rd_meta(rd_meta), .rd_data(rd_data),
        .data_we(data_we), .meta_we(meta_we), .wr_idx(wr_idx), .wr_way(wr_way),
        .wr_word(wr_word), .wr_data(wr_data), .wr_meta(wr_meta)
    );

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        vfound  = 1'b0;
        vsel    = rr[req_idx];
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && rd_meta[w].valid && rd_meta[w].tag == req_tag) begin
                hit     = 1'b1;
                hit_way = WYW'(w);
            end
            if (!vfound && !rd_meta[w].valid) begin
                vfound = 1'b1;
                vsel   = WYW'(w);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= nstate;
    end

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE: begin
                if (halt)             nstate = FLUSH;
                else if (req && !hit) nstate = (rd_meta[vsel].valid && rd_meta[vsel].dirty) ? WB : ALLOC;
            end
            WB:      if (xfer && wlast) nstate = ALLOC;
            ALLOC:   if (xfer && wlast) nstate = IDLE;
            FLUSH:   if (fstep && flast) nstate = DONE;
            DONE:    nstate = DONE;
            default: nstate = IDLE;
        endcase
    end

    always_comb begin
        dhit     = 1'b0;
        dmemload = '0;
        flushed  = 1'b0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        daddr    = '0;
        dstore   = '0;
        unique case (state)
            IDLE: if (!halt && req && hit) begin
                dhit     = 1'b1;
                dmemload = rd_data[hit_way][req_word];
            end
            WB: begin
                dWEN   = 1'b1;
                daddr  = blk_addr(rd_meta[vway].tag, miss_idx, wcnt);
                dstore = rd_data[vway][wcnt];
            end
            ALLOC: begin
                dREN  = 1'b1;
                daddr = blk_addr(miss_tag, miss_idx, wcnt);
            end
            FLUSH: if (fdirty) begin
                dWEN   = 1'b1;
                daddr  = blk_addr(fframe.tag, fset, wcnt);
                dstore = rd_data[fway][wcnt];
            end
            DONE:    flushed = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        data_we = 1'b0;
        meta_we = 1'b0;
        wr_idx  = miss_idx;
        wr_way  = vway;
        wr_word = wcnt;
        wr_data = dload;
        wr_meta = '0;
        unique case (state)
            IDLE: if (!halt && dmemWEN && hit) begin
                data_we       = 1'b1;
                meta_we       = 1'b1;
                wr_idx        = req_idx;
                wr_way        = hit_way;
                wr_word       = req_word;
                wr_data       = dmemstore;
                wr_meta.valid = 1'b1;
                wr_meta.dirty = 1'b1;
                wr_meta.tag   = req_tag;
            end
            ALLOC: if (xfer) begin
                data_we       = 1'b1;
                meta_we       = wlast;
                wr_meta.valid = 1'b1;
                wr_meta.tag   = miss_tag;
            end
            FLUSH: if (fdirty && xfer && wlast) begin
                meta_we       = 1'b1;
                wr_idx        = fset;
                wr_way        = fway;
                wr_meta.valid = 1'b1;
                wr_meta.tag   = fframe.tag;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wcnt     <= '0;
            fset     <= '0;
            fway     <= '0;
            vway     <= '0;
            miss_idx <= '0;
            miss_tag <= '0;
            for (int s = 0; s < SETS; s++) rr[s] <= '0;
        end else begin
            // Latch the miss so a request that drops or changes mid-fill cannot disturb it.
            if (state == IDLE && !halt && req && !hit) begin
                miss_idx <= req_idx;
                miss_tag <= req_tag;
                vway     <= vsel;
            end
            if (xfer) wcnt <= wlast ? '0 : wcnt + 1'b1;
            if (state == ALLOC && xfer && wlast)
                rr[miss_idx] <= (rr[miss_idx] + 1'b1) & WYW'(WAYS - 1);
            if (fstep) begin
                fway <= (fway == WYW'(WAYS - 1)) ? '0 : fway + 1'b1;
                if (fway == WYW'(WAYS - 1)) fset <= fset + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dcache_assoc.sv
// Directed bench for dcache_assoc: default geometry plus a 4x4x4 instance for
// reset during writeback. Memory transfers are scored against an expected queue.
module tb_dcache_assoc;
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RST0, REN0, WEN0, halt0, dhit0, flushed0, dREN0, dWEN0, dwait0;
    logic [31:0] addr0, store0, load0, daddr0, dstore0, dload0;
    logic        rst1, REN1, WEN1, halt1, dhit1, flushed1, dREN1, dWEN1, dwait1;
    logic [31:0] addr1, store1, load1, daddr1, dstore1, dload1;

    dcache_assoc u0 (
        .CLK(CLK), .RST(RST0), .dmemREN(REN0), .dmemWEN(WEN0), .dmemaddr(addr0),
        .dmemstore(store0), .halt(halt0), .dhit(dhit0), .dmemload(load0),
        .flushed(flushed0), .dREN(dREN0), .dWEN(dWEN0), .daddr(daddr0),
        .dstore(dstore0), .dwait(dwait0), .dload(dload0)
    );

    dcache_assoc #(.SETS(4), .WAYS(4), .WORDS(4)) u1 (
        .CLK(CLK), .RST(rst1), .dmemREN(REN1), .dmemWEN(WEN1), .dmemaddr(addr1),
        .dmemstore(store1), .halt(halt1), .dhit(dhit1), .dmemload(load1),
        .flushed(flushed1), .dREN(dREN1), .dWEN(dWEN1), .daddr(daddr1),
        .dstore(dstore1), .dwait(dwait1), .dload(dload1)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] a;
        logic [31:0] d;
    } xfer_t;

    xfer_t       exp_q[$];
    logic [31:0] ld_q[$];
    logic [31:0] sh [0:1023];
    int          nvec = 0;
    int          nerr = 0;
    int          stall = 0;
    int          wait_cfg = 0;
    logic        stalled = 1'b0;
    logic [31:0] s_addr = '0, s_data = '0;

    // Memory for u0: the processor-visible image doubles as backing store for absent blocks.
    assign dwait0 = (dREN0 || dWEN0) && (stall < wait_cfg);
    always @(posedge CLK) if (dREN0 || dWEN0) stall <= (stall < wait_cfg) ? stall + 1 : 0;
    always @(negedge CLK) dload0 <= sh[daddr0[11:2]];

    assign dwait1 = 1'b0;
    assign dload1 = 32'hF000_0000 ^ daddr1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_x(input logic we, input logic [31:0] a);
        xfer_t x;
        x.we = we;
        x.a  = a;
        x.d  = we ? sh[a[11:2]] : 32'h0;
        exp_q.push_back(x);
    endtask

    always @(negedge CLK) begin
        if (!RST0 && (dREN0 || dWEN0)) begin
            xfer_t x;
            check("u0_excl", 32'(dREN0 & dWEN0), 32'h0);
            if (stalled) begin
                check("stall_addr", daddr0, s_addr);
                check("stall_data", dstore0, s_data);
            end
            stalled <= dwait0;
            s_addr  <= daddr0;
            s_data  <= dstore0;
            if (!dwait0) begin
                check("xfer_expected", 32'(exp_q.size() > 0), 32'h1);
                if (exp_q.size() > 0) begin
                    x = exp_q.pop_front();
                    check("xfer_we", 32'(dWEN0), 32'(x.we));
                    check("xfer_addr", daddr0, x.a);
                    if (x.we) check("xfer_data", dstore0, x.d);
                end
            end
        end else begin
            stalled <= 1'b0;
        end
    end

    task automatic acc0(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input int lat, input string tag);
        int n;
        logic [31:0] ev;
        @(posedge CLK); #1;
        REN0 = !we; WEN0 = we; addr0 = a; store0 = d;
        if (!we) ld_q.push_back(sh[a[11:2]]);
        n = 0;
        @(negedge CLK);
        while (!dhit0 && n < 200) begin n++; @(negedge CLK); end
        check({tag, "_lat"}, 32'(n), 32'(lat));
        if (!we) begin
            ev = ld_q.pop_front();
            check({tag, "_load"}, load0, ev);
        end else begin
            sh[a[11:2]] = d;
        end
        @(posedge CLK); #1;
        REN0 = 1'b0; WEN0 = 1'b0;
    endtask

    task automatic acc1(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input int lat, input logic [31:0] ev, input string tag);
        int n;
        @(posedge CLK); #1;
        REN1 = !we; WEN1 = we; addr1 = a; store1 = d;
        n = 0;
        @(negedge CLK);
        while (!dhit1 && n < 200) begin n++; @(negedge CLK); end
        check({tag, "_lat"}, 32'(n), 32'(lat));
        if (!we) check({tag, "_load"}, load1, ev);
        @(posedge CLK); #1;
        REN1 = 1'b0; WEN1 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 1024; i++) sh[i] = 32'hC0DE_0000 | (32'(i) << 2);
        RST0 = 1'b1; REN0 = 1'b0; WEN0 = 1'b0; addr0 = '0; store0 = '0; halt0 = 1'b0;
        rst1 = 1'b1; REN1 = 1'b0; WEN1 = 1'b0; addr1 = '0; store1 = '0; halt1 = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_u0_ctl", {28'h0, dhit0, flushed0, dREN0, dWEN0}, 32'h0);
        check("rst_u0_bus", daddr0 | dstore0 | load0, 32'h0);
        check("rst_u1_ctl", {28'h0, dhit1, flushed1, dREN1, dWEN1}, 32'h0);
        @(posedge CLK); #1;
        RST0 = 1'b0; rst1 = 1'b0;

        // Cold read, then hit, then write hit / read-back with no traffic.
        push_x(0, 32'h100); push_x(0, 32'h104);
        acc0(0, 32'h100, 0, 3, "cold_rd");
        acc0(0, 32'h100, 0, 0, "rehit");
        acc0(1, 32'h100, 32'hDEAD_BEEF, 0, "wr_hit");
        acc0(0, 32'h100, 0, 0, "rd_after_wr");

        // Second way of set 0, then a third tag evicts the dirty way 0.
        push_x(0, 32'h040); push_x(0, 32'h044);
        acc0(0, 32'h040, 0, 3, "fill_b");
        push_x(1, 32'h100); push_x(1, 32'h104); push_x(0, 32'h1C0); push_x(0, 32'h1C4);
        acc0(0, 32'h1C0, 0, 5, "dirty_evict");
        // Pointer now 1: the next miss replaces way 1 and leaves tag C resident.
        push_x(0, 32'h080); push_x(0, 32'h084);
        acc0(0, 32'h080, 0, 3, "rr_way1");
        acc0(0, 32'h1C0, 0, 0, "c_kept");

        // Three wait cycles per transfer on a clean-victim miss.
        wait_cfg = 3;
        push_x(0, 32'h200); push_x(0, 32'h204);
        acc0(0, 32'h200, 0, 9, "stall_miss");
        wait_cfg = 0;

        // Dirty blocks in sets 1 and 5, clean block in set 2, then flush.
        push_x(0, 32'h008); push_x(0, 32'h00C);
        acc0(1, 32'h008, 32'h1111_0008, 3, "wr_miss_s1");
        push_x(0, 32'h028); push_x(0, 32'h02C);
        acc0(1, 32'h02C, 32'h5555_002C, 3, "wr_miss_s5");
        push_x(0, 32'h010); push_x(0, 32'h014);
        acc0(0, 32'h010, 0, 3, "clean_s2");
        push_x(1, 32'h008); push_x(1, 32'h00C); push_x(1, 32'h028); push_x(1, 32'h02C);
        @(posedge CLK); #1;
        halt0 = 1'b1; REN0 = 1'b1; addr0 = 32'h008;
        @(negedge CLK);
        check("halt_prio_dhit", 32'(dhit0), 32'h0);
        n = 0;
        while (!flushed0 && n < 200) begin n++; @(negedge CLK); end
        check("flush_lat", 32'(n), 32'd19);
        repeat (5) @(negedge CLK);
        check("flushed_held", 32'(flushed0), 32'h1);
        check("done_quiet", {29'h0, dhit0, dREN0, dWEN0}, 32'h0);
        check("sb_empty", 32'(exp_q.size()), 32'h0);

        // 4x4x4: fill set 0, dirty way 0, then reset in the middle of its writeback.
        acc1(0, 32'h000, 0, 5, 32'hF000_0000, "u1_fill0");
        acc1(0, 32'h040, 0, 5, 32'hF000_0040, "u1_fill1");
        acc1(0, 32'h080, 0, 5, 32'hF000_0080, "u1_fill2");
        acc1(0, 32'h0C0, 0, 5, 32'hF000_00C0, "u1_fill3");
        acc1(1, 32'h000, 32'h1234_5678, 0, 0, "u1_wr");
        acc1(0, 32'h000, 0, 0, 32'h1234_5678, "u1_rd_hit");
        @(posedge CLK); #1;
        REN1 = 1'b1; addr1 = 32'h100;
        n = 0;
        @(negedge CLK);
        while (!dWEN1 && n < 20) begin n++; @(negedge CLK); end
        check("u1_wb_start", 32'(n), 32'h1);
        repeat (2) @(negedge CLK);
        check("u1_wb_addr", daddr1, 32'h0000_0008);
        @(posedge CLK); #1;
        rst1 = 1'b1;
        @(negedge CLK);
        check("u1_wb_before_rst", 32'(dWEN1), 32'h1);
        @(negedge CLK);
        check("u1_rst_drop", {30'h0, dREN1, dWEN1}, 32'h0);
        @(posedge CLK); #1;
        rst1 = 1'b0; REN1 = 1'b0;
        acc1(0, 32'h000, 0, 5, 32'hF000_0000, "u1_post_rst0");
        acc1(0, 32'h040, 0, 5, 32'hF000_0040, "u1_post_rst1");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/dcache_assoc.md
# dcache_assoc

Parametrised, write-back, write-allocate, N-way set-associative data cache between the datapath data port and the memory arbiter. It generalises the fixed 8-set, 2-way, 2-word data cache to configurable sets, ways and block size. It adds deterministic victim selection and a halt-triggered flush sequence that writes back every dirty block before the core stops.

## Interface
- SETS, 8, number of sets (power of two, ≥2)
- WAYS, 2, associativity (power of two, ≥1)
- WORDS, 2, 32-bit words per block (power of two, ≥1)
- CLK  in  1  clock, rising edge
- RST  in  1  reset; synchronous, active-high
- dmemREN  in  1  datapath read request
- dmemWEN  in  1  datapath write request (never both high with dmemREN)
- dmemaddr  in  32  byte address, word aligned
- dmemstore  in  32  write data
- halt  in  1  datapath halt; level, held until reset
- dhit  out  1  request completed this cycle
- dmemload  out  32  read data, valid when dhit
- flushed  out  1  flush complete, held until reset
- dREN  out  1  memory read request
- dWEN  out  1  memory write request
- daddr  out  32  memory word address
- dstore  out  32  memory write data
- dwait  in  1  memory busy; a transfer completes on a cycle with request high and dwait low
- dload  in  32  memory read data, valid when the read completes

## Operation
- Address split, LSB first:
  - byte offset: 2 bits
  - block offset: log2(WORDS) bits
  - index: log2(SETS) bits
  - tag: remaining bits
- Per-frame state: valid, dirty, tag, WORDS data words. Per-set state: round-robin victim pointer, log2(WAYS) bits.
- Hit: a valid way in the indexed set has a matching tag.
  - Read hit: dmemload = the addressed word.
  - Write hit: the word and the dirty bit update at the clock edge.
- Victim selection: the lowest-index invalid way; if all ways are valid, the way at the round-robin pointer. The pointer increments, modulo WAYS, on each completed fill of that set.
- FSM states:
  - IDLE: serve hits. On a miss, go to WB if the victim is dirty, else to ALLOC. If halt is high, go to FLUSH; halt has priority over a simultaneous request, and dhit stays low.
  - WB: issue WORDS writes of the victim block, words 0 to WORDS-1, at address {victim tag, index, word, 2'b00}. After the last write, go to ALLOC.
  - ALLOC: issue WORDS reads of the requested block, words 0 to WORDS-1. After the last read, set valid, clear dirty, write the tag and return to IDLE. The retried request then hits.
  - FLUSH: walk set 0 to SETS-1 and, within each set, way 0 to WAYS-1. Each dirty frame is written back word by word and its dirty bit cleared. Clean or invalid frames cost one cycle each. After the final frame, go to DONE.
  - DONE: flushed=1; all outputs other than flushed stay quiescent until reset.
- A single word counter, log2(WORDS) bits, sequences both WB and ALLOC. A set/way counter sequences FLUSH.

## Timing
- Reset: all valid and dirty bits, victim pointers and counters cleared; state IDLE. Outputs reset to: dhit=0, flushed=0, dREN=0, dWEN=0, daddr=0, dstore=0, dmemload=0.
- Hit latency: 0 cycles. dhit is combinational in IDLE on a hit; dhit is never high outside IDLE.
- Miss latency, zero-wait memory: clean victim = WORDS+1 cycles to dhit; dirty victim = 2·WORDS+1 cycles.
- Memory handshake:
  - dREN/dWEN, daddr and dstore are held stable until the cycle dwait is low.
  - The word counter advances only on that cycle.
  - dREN and dWEN are never high together.
- If the request drops or changes mid-miss, the fill still completes. The new request is evaluated fresh in IDLE.
- RST asserted during WB, ALLOC or FLUSH: memory requests drop on the next edge and all contents are invalidated. The partial writeback is discarded.

## Structure
- The shared cpu_types_pkg holds:
  - address-split field widths as localparam functions of the parameters
  - the frame struct typedef
  - the dcache state enum
  - the WORD_W=32 constant
- The tag/data array is one sub-module, dcache_set_array. It provides combinational read of all ways of one set and a single-word write port with valid/dirty/tag update. The FSM and victim logic stay in dcache_assoc.

## Test plan
- Default parameters. Read 0x0000_0100 cold with dwait=0 → two dREN transfers at word addresses 0x100 and 0x104. dhit occurs on cycle 3 with dmemload = memory[0x100]. An immediate re-read hits in 0 cycles.
- Write 0xDEAD_BEEF to 0x100, then read 0x100 → dhit on the same cycle as the read, returning 0xDEAD_BEEF. No memory traffic.
- Fill set 0 through both ways using tags A and B, with way 0 dirty. Access tag C → writeback of way 0 (2 dWEN transfers at tag A addresses), then 2 reads. The pointer advances to 1.
- dwait held high for 3 cycles on each transfer → daddr and dstore stay stable. Miss completes in 2·4+1 cycles for a clean victim.
- Dirty blocks at sets 1 and 5 plus a clean block elsewhere, then raise halt → dWEN only for the 4 dirty words. flushed=1 after the walk of all 16 frames; flushed stays 1.
- SETS=4, WAYS=4, WORDS=4. RST asserted mid-WB → dWEN drops the next cycle and all frames are invalid. A subsequent read misses.
